// File: rtl/spi_reg_master.sv
// Mode-0 SPI master for single register transactions: one {rd, addr} command
// byte followed by one data byte, framed by one chip-select assertion.
module spi_reg_master #(
   parameter int CLK_DIV       = 4,
   parameter int NUM_ADDR_BITS = 7,
   parameter int NUM_DATA_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     rd,
   input  logic [NUM_ADDR_BITS-1:0] addr,
   input  logic [NUM_DATA_BITS-1:0] wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_DATA_BITS-1:0] rd_data,
   output logic                     spi_cs0,
   output logic                     spi_clk,
   output logic                     spi_mosi,
   input  logic                     spi_miso
);

   localparam int FRAME_BITS = 1 + NUM_ADDR_BITS + NUM_DATA_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

   state_t                  state;
   logic [7:0]              div_cnt;
   logic [CNT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-2:0]   tx_shift;
   logic [NUM_DATA_BITS-1:0] rx_shift;
   logic                    rd_latched;
   logic [FRAME_BITS-1:0]   frame_word;
   logic                    div_wrap;

   assign frame_word = {rd, addr, (rd ? {NUM_DATA_BITS{1'b0}} : wr_data)};
   assign div_wrap   = (div_cnt == 8'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         tx_shift   <= '0;
         rx_shift   <= '0;
         rd_latched <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_data    <= '0;
         spi_cs0    <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_shift   <= frame_word[FRAME_BITS-2:0];
                  spi_mosi   <= frame_word[FRAME_BITS-1];
                  rd_latched <= rd;
                  spi_cs0    <= 1'b0;
                  busy       <= 1'b1;
                  div_cnt    <= '0;
                  bit_cnt    <= '0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  spi_clk <= ~spi_clk;
                  // Falling toggle: end of the high phase, sample and advance
                  if (spi_clk) begin
                     rx_shift <= {rx_shift[NUM_DATA_BITS-2:0], spi_miso};
                     tx_shift <= {tx_shift[FRAME_BITS-3:0], 1'b0};
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                        spi_mosi <= 1'b0;
                        state    <= HOLD;
                     end else begin
                        spi_mosi <= tx_shift[FRAME_BITS-2];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            HOLD: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  spi_cs0 <= 1'b1;
                  done    <= 1'b1;
                  if (rd_latched) rd_data <= rx_shift;
                  state   <= GAP;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            GAP: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI master that issues single register transactions to the FPGA's SPI register slave: one 8-bit command byte followed by one 8-bit data byte. It serves on-chip sequencers and loop-back self-test, and drives external SPI register devices that use the same frame. Each transaction is one 16-bit frame inside a single chip-select assertion. Timing is SPI mode 0 with a programmable SCLK divider.

## Interface
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255
- NUM_ADDR_BITS, 7, address width; the command byte is {rd, addr}
- NUM_DATA_BITS, 8, data byte width
- clk  in  1  system clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a transaction; sampled only while busy=0
- rd  in  1  1 = read, 0 = write; latched with start
- addr  in  NUM_ADDR_BITS  register address; latched with start
- wr_data  in  NUM_DATA_BITS  write data; latched with start
- busy  out  1  transaction in progress, including the CS-high gap
- done  out  1  one-cycle pulse at the end of the frame
- rd_data  out  NUM_DATA_BITS  last read result
- spi_cs0  out  1  chip select, active low
- spi_clk  out  1  SCLK; idles low
- spi_mosi  out  1  serial data to the slave, MSB first
- spi_miso  in  1  serial data from the slave

## Operation
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE: all outputs at idle values. When start=1 the block:
  - latches the 16-bit frame {rd, addr, wr_data}, or {rd, addr, 8'h00} when rd=1;
  - sets spi_cs0=0, busy=1, and spi_mosi = frame bit 15;
  - goes to SHIFT and clears the divider and bit counter.
- SHIFT: the divider counts 0..CLK_DIV-1. At each wrap spi_clk toggles.
  - On a rising toggle, nothing else changes.
  - On a falling toggle:
    - spi_miso is sampled into the receive shift register. Sampling at the end of the high phase gives the slave a full half-period after its own falling-edge update.
    - spi_mosi advances to the next frame bit.
    - The bit counter increments.
  - After the 16th falling toggle, go to HOLD with spi_mosi=0.
- HOLD: spi_clk stays low for CLK_DIV cycles. Then spi_cs0=1, done=1 for one cycle, and state goes to GAP.
  - If rd=1, rd_data takes the low 8 received bits in the same cycle; otherwise rd_data holds its value.
- GAP: spi_cs0 stays high for CLK_DIV cycles, then busy=0 and state returns to IDLE.
- start while busy=1 is ignored and never queued.
- Received bits from the command byte are discarded.
- spi_miso is used directly with no synchronizer; the slave's timing is covered by the half-period margin.

## Timing
- Reset values: spi_cs0=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rd_data=0, state=IDLE.
- Edge numbering: edge 0 is the rising clk edge that samples start=1 in IDLE; D = CLK_DIV.
- After edge 0: spi_cs0=0, busy=1, spi_mosi=bit15. Outputs are registered, so they change one cycle after start is sampled.
- Bit k (k=0..15):
  - spi_clk rises at edge (2k+1)·D and falls at edge (2k+2)·D;
  - spi_miso is sampled at edge (2k+2)·D;
  - spi_mosi changes at edge (2k+2)·D for k<15.
- Edge 33·D: spi_cs0=1, done=1, rd_data updated.
- Edge 33·D+1: done=0.
- Edge 34·D: busy=0. The earliest next start is sampled at edge 34·D+1.
- D=4: first rise at edge 4, last fall at edge 128, done at edge 132, busy low at edge 136.
- Reset mid-frame: outputs go immediately (asynchronously) to reset values. No done pulse is issued and rd_data is cleared.

## Test plan
- Write frame, D=4: start with rd=0, addr=7'h03, wr_data=8'hA5.
  - MOSI bits sampled on spi_clk rising edges equal 16'h03A5.
  - Exactly 16 rising edges; spi_cs0 low for edges 1..132.
  - done pulses once at edge 132; rd_data stays 8'h00.
- Read frame against a mode-0 slave model returning 8'h5C: rd=1, addr=7'h11.
  - MOSI equals 16'h9100.
  - rd_data=8'h5C at edge 132, with done high in the same cycle.
- Back-to-back: start held high continuously.
  - The second frame's spi_cs0 falls at edge 137.
  - spi_cs0 is high for at least 4 cycles between frames.
  - Two done pulses in total.
- Start ignored: pulse start with addr=7'h7F at edge 50 of a running write to 7'h00.
  - Only one frame is transmitted; its address is 7'h00.
- Divider extremes: D=2 and D=255.
  - SCLK half-period is exactly D cycles.
  - done occurs at edge 66 and edge 8415 respectively.
- Reset at edge 60 mid-frame:
  - spi_cs0=1, spi_clk=0, busy=0 within the same cycle, with no done pulse.
  - A new read after reset release completes normally.
